// File: rtl/fpu_mul_scheduler.sv
// fpu_mul_scheduler: shares one combinational FP multiplier between two
// requesters. Each operation is accepted in IDLE, multiplied in EXEC and
// returned in RESP. After each response, the round-robin pointer passes to
// the other requester.
module fpu_mul_scheduler #(
  parameter int D_WIDTH   = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [D_WIDTH-1:0]   req0_a,
  input  logic [D_WIDTH-1:0]   req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [D_WIDTH-1:0]   req1_a,
  input  logic [D_WIDTH-1:0]   req1_b,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [D_WIDTH-1:0]   rsp_data,
  output logic [D_WIDTH-1:0]   mul_a,
  output logic [D_WIDTH-1:0]   mul_b,
  input  logic [D_WIDTH-1:0]   mul_result,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_cnt0,
  output logic [CNT_WIDTH-1:0] op_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state_reg;
  logic                 ptr_reg;
  logic                 owner_reg;
  logic [D_WIDTH-1:0]   op_a_reg;
  logic [D_WIDTH-1:0]   op_b_reg;
  logic [D_WIDTH-1:0]   result_reg;
  logic [1:0]           rsp_valid_reg;
  logic                 busy_reg;

  logic                 grant_valid;
  logic                 grant_idx;
  logic                 rsp_hs;

  // Arbitration: a lone requester wins outright, a tie goes to ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (state_reg == IDLE) begin
      grant_valid = req0_valid | req1_valid;
      grant_idx   = (req0_valid & req1_valid) ? ptr_reg : req1_valid;
    end
  end

  assign req0_ready = grant_valid & ~grant_idx;
  assign req1_ready = grant_valid &  grant_idx;

  // The response completes only when the owner's ready is seen in RESP.
  // The other requester's ready is ignored.
  assign rsp_hs = (state_reg == RESP) &&
                  (owner_reg ? rsp1_ready : rsp0_ready);

  // Main sequencer: latches the operands, captures the product and holds the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      owner_reg     <= 1'b0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      result_reg    <= '0;
      rsp_valid_reg <= 2'b00;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            op_a_reg  <= grant_idx ? req1_a : req0_a;
            op_b_reg  <= grant_idx ? req1_b : req0_b;
            owner_reg <= grant_idx;
            busy_reg  <= 1'b1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          result_reg    <= mul_result;
          rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
          state_reg     <= RESP;
        end
        RESP: begin
          // Return to IDLE without accepting a request, so the next grant
          // happens in IDLE one cycle later.
          if (rsp_hs) begin
            rsp_valid_reg <= 2'b00;
            busy_reg      <= 1'b0;
            ptr_reg       <= ~owner_reg;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 2'b00;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Per-requester saturating completion counters.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      // Advance when this requester's response completes; stop at all-ones.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (rsp_hs && (owner_reg == 1'(gi)) && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign op_cnt0    = g_cnt[0].cnt_reg;
  assign op_cnt1    = g_cnt[1].cnt_reg;
  assign mul_a      = op_a_reg;
  assign mul_b      = op_b_reg;
  assign rsp_data   = result_reg;
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign busy       = busy_reg;

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Bench for fpu_mul_scheduler. A toy FP multiplier drives mul_result.
// Expected products come from hand-computed constants.
// Responses are matched through a scoreboard queue.
module tb_fpu_mul_scheduler;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_data, mul_a, mul_b, mul_result;
  logic          busy;
  logic [CW-1:0] op_cnt0, op_cnt1;

  int checks   = 0;
  int failures = 0;
  int mcnt [2];

  typedef struct {
    int          owner;
    logic [31:0] data;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    bit          v0;
    bit          v1;
    logic [31:0] a0, b0, a1, b1;
    int          exp_owner;
    logic [31:0] exp_data;
    int          hold;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  fpu_mul_scheduler #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .busy(busy), .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
  );

  // Truncating single-precision multiply for normal operands; zero in gives signed zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [9:0]  e;
    logic [47:0] p;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      e = e + 10'd1;
      return {s, e[7:0], p[46:24]};
    end
    return {s, e[7:0], p[45:23]};
  endfunction

  assign mul_result = fmul(mul_a, mul_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit v0, input bit v1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input int exp_owner, input logic [31:0] exp_data,
                        input int hold, input string tag);
    exp_t e;
    int   own;
    bit   got;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk({tag, " accept"}, 32'(got), 32'd1);
    if (!got) return;
    own = req1_ready ? 1 : 0;
    chk({tag, " grant"}, own, exp_owner);
    chk({tag, " one_ready"}, 32'(req0_ready & req1_ready), 32'd0);
    sb.push_back('{own, exp_data});
    step();  // EXEC
    chk({tag, " exec_busy"}, 32'(busy), 32'd1);
    chk({tag, " exec_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk({tag, " exec_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    chk({tag, " mul_a"}, mul_a, own ? a1 : a0);
    step();  // RESP at N+2
    e = sb.pop_front();
    chk({tag, " rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, e.owner ? 32'd2 : 32'd1);
    chk({tag, " rsp_data"}, rsp_data, e.data);
    // Hold the owner's ready low; the other's ready must be ignored.
    rsp0_ready = (e.owner == 1);
    rsp1_ready = (e.owner == 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, " hold_valid"}, {30'd0, rsp1_valid, rsp0_valid}, e.owner ? 32'd2 : 32'd1);
      chk({tag, " hold_data"}, rsp_data, e.data);
      chk({tag, " hold_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      chk({tag, " hold_busy"}, 32'(busy), 32'd1);
    end
    rsp0_ready = (e.owner == 0);
    rsp1_ready = (e.owner == 1);
    #1;
    chk({tag, " hs_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    if (mcnt[e.owner] < 15) mcnt[e.owner]++;
    chk({tag, " cnt0"}, 32'(op_cnt0), mcnt[0]);
    chk({tag, " cnt1"}, 32'(op_cnt1), mcnt[1]);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " idle_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    mcnt[0] = 0;
    mcnt[1] = 0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst mul_a", mul_a, 32'd0);
    chk("rst mul_b", mul_b, 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst cnt", {op_cnt1, op_cnt0}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running after %0t", $time);
    $fatal(1);
  end

  initial begin
    // From reset with both valid: 0,1,0,1, then single/held mixes.
    vecs[0] = '{1, 1, 32'h40000000, 32'h40400000, 32'h3FC00000, 32'h40000000, 0, 32'h40C00000, 0};
    vecs[1] = '{1, 1, 32'h40800000, 32'h3F000000, 32'h3FC00000, 32'h40000000, 1, 32'h40400000, 0};
    vecs[2] = '{1, 1, 32'h40800000, 32'h3F000000, 32'hBF800000, 32'h40000000, 0, 32'h40000000, 0};
    vecs[3] = '{1, 1, 32'h40400000, 32'h40400000, 32'hBF800000, 32'h40000000, 1, 32'hC0000000, 0};
    vecs[4] = '{1, 0, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 0, 32'h3F800000, 0};
    vecs[5] = '{1, 1, 32'h40000000, 32'h40000000, 32'h3FC00000, 32'h3FC00000, 1, 32'h40100000, 5};
    vecs[6] = '{1, 1, 32'h3F000000, 32'h3F000000, 32'h40400000, 32'hC0000000, 0, 32'h3E800000, 0};
    vecs[7] = '{1, 1, 32'h3F000000, 32'h3F000000, 32'h40400000, 32'hC0000000, 1, 32'hC0C00000, 2};

    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    do_reset();
    run_op(1, 0, 32'h40000000, 32'h40400000, 0, 0, 0, 32'h40C00000, 0, "single_req0");
    chk("single_req0 cnt0_is_1", 32'(op_cnt0), 32'd1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
             vecs[i].exp_owner, vecs[i].exp_data, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // A request withdrawn before any clock edge sees it is simply not taken.
    req0_valid = 0;
    req1_valid = 1;
    #1;
    chk("drop ready1", 32'(req1_ready), 32'd1);
    req1_valid = 0;
    step();
    chk("drop busy", 32'(busy), 32'd0);

    // Reset while in EXEC drops the operation without a response.
    req0_valid = 1;
    req0_a = 32'h40000000;
    req0_b = 32'h40400000;
    #1;
    chk("abort ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 0;
    chk("abort exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    chk("abort busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      step();
    end
    chk("abort cnt", {op_cnt1, op_cnt0}, 32'd0);

    // Sixteen ops on req0 against a 4-bit counter: it must saturate.
    for (int i = 0; i < 16; i++) begin
      run_op(1, 0, 32'h40000000, 32'h40400000, 0, 0, 0, 32'h40C00000, 0, $sformatf("sat%0d", i));
    end
    chk("sat cnt0_max", 32'(op_cnt0), 32'hF);

    chk("sb empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
